// File: rtl/interval_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : interval_seq_pkg
// Brief  : Shared types and default sizes for the interval sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package interval_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_REP_W = 8;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  // One table entry at the default sizes
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] cycles;
    logic [DEFAULT_REP_W-1:0] reps;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/interval_table.sv
`default_nettype none
// ============================================================================
// Module : interval_table
// Brief  : DEPTH-entry (cycles, reps) flop array, one write port and one
//          asynchronous read port. Cleared by reset.
// Rev    : 1.0  initial release
// ============================================================================
module interval_table #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int REP_W = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_cycles_i,
  input  logic [REP_W-1:0] wr_reps_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [WIDTH-1:0] rd_cycles_o,
  output logic [REP_W-1:0] rd_reps_o
);

  logic [WIDTH-1:0] cycles_q [DEPTH];
  logic [REP_W-1:0] reps_q   [DEPTH];

  // Storage: cleared on reset, single entry updated per write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cycles_q[i] <= '0;
        reps_q[i]   <= '0;
      end
    end else if (wr_en_i) begin
      cycles_q[wr_addr_i] <= wr_cycles_i;
      reps_q[wr_addr_i]   <= wr_reps_i;
    end
  end

  assign rd_cycles_o = cycles_q[rd_idx_i];
  assign rd_reps_o   = reps_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/interval_sequencer.sv
`default_nettype none
// ============================================================================
// Module : interval_sequencer
// Brief  : Plays a table of (cycles, reps) entries into a repeating cycle
//          timer: loads each interval, counts reps elapsed pulses, advances,
//          optionally wrapping back to entry 0.
// Rev    : 1.0  initial release
// ============================================================================
module interval_sequencer
  import interval_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int REP_W = DEFAULT_REP_W,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_cycles_i,
  input  logic [REP_W-1:0] wr_reps_i,
  input  logic [IDX_W-1:0] last_idx_i,
  input  logic             loop_en_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             timer_load_o,
  output logic [WIDTH-1:0] timer_cycles_o,
  input  logic             timer_elapsed_i,
  output logic             busy_o,
  output logic             step_o,
  output logic [IDX_W-1:0] entry_idx_o,
  output logic             done_o
);

  state_t           state_q;
  logic [IDX_W-1:0] entry_idx_q;
  logic [IDX_W-1:0] last_q;
  logic             loop_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic [REP_W-1:0] reps_q;        // effective reps of the playing entry (>=1)
  logic [WIDTH-1:0] timer_cycles_q;
  logic             timer_load_q;
  logic             busy_q;
  logic             step_q;
  logic             done_q;

  logic [IDX_W-1:0] next_idx_d;
  logic [IDX_W-1:0] rd_idx_d;
  logic             wr_ok_d;
  logic [WIDTH-1:0] rd_cycles;
  logic [REP_W-1:0] rd_reps;
  logic [WIDTH-1:0] load_cycles_d;
  logic [REP_W-1:0] load_reps_raw;
  logic [REP_W-1:0] load_reps_d;
  logic             rep_last_d;

  // The table is frozen while a sequence is active
  assign wr_ok_d = wr_en_i && (state_q == IDLE);

  interval_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .REP_W (REP_W)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_ok_d),
    .wr_addr_i   (wr_addr_i),
    .wr_cycles_i (wr_cycles_i),
    .wr_reps_i   (wr_reps_i),
    .rd_idx_i    (rd_idx_d),
    .rd_cycles_o (rd_cycles),
    .rd_reps_o   (rd_reps)
  );

  // Next entry to load: entry 0 on start, otherwise the successor (or wrap).
  // A write to entry 0 coinciding with start is forwarded so the first load
  // already sees the new contents.
  always_comb begin
    next_idx_d    = (entry_idx_q < last_q) ? entry_idx_q + 1'b1 : '0;
    rd_idx_d      = (state_q == IDLE) ? '0 : next_idx_d;
    load_cycles_d = rd_cycles;
    load_reps_raw = rd_reps;
    if (wr_ok_d && (wr_addr_i == '0)) begin
      load_cycles_d = wr_cycles_i;
      load_reps_raw = wr_reps_i;
    end
    load_reps_d   = (load_reps_raw == '0) ? REP_W'(1) : load_reps_raw;
    rep_last_d    = (rep_cnt_q == reps_q - 1'b1);
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      entry_idx_q    <= '0;
      last_q         <= '0;
      loop_q         <= 1'b0;
      rep_cnt_q      <= '0;
      reps_q         <= '0;
      timer_cycles_q <= '0;
      timer_load_q   <= 1'b0;
      busy_q         <= 1'b0;
      step_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      timer_load_q <= 1'b0;
      step_q       <= (state_q == WAIT) && timer_elapsed_i;
      done_q       <= 1'b0;
      if (stop_i) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        rep_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q        <= LOAD;
              busy_q         <= 1'b1;
              entry_idx_q    <= '0;
              rep_cnt_q      <= '0;
              last_q         <= last_idx_i;
              loop_q         <= loop_en_i;
              timer_load_q   <= 1'b1;
              timer_cycles_q <= load_cycles_d;
              reps_q         <= load_reps_d;
            end
          end
          LOAD: begin
            state_q <= WAIT;
          end
          WAIT: begin
            if (timer_elapsed_i) begin
              if (!rep_last_d) begin
                rep_cnt_q <= rep_cnt_q + 1'b1;
              end else begin
                rep_cnt_q <= '0;
                if ((entry_idx_q < last_q) || loop_q) begin
                  state_q        <= LOAD;
                  entry_idx_q    <= next_idx_d;
                  timer_load_q   <= 1'b1;
                  timer_cycles_q <= load_cycles_d;
                  reps_q         <= load_reps_d;
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign timer_load_o   = timer_load_q;
  assign timer_cycles_o = timer_cycles_q;
  assign busy_o         = busy_q;
  assign step_o         = step_q;
  assign entry_idx_o    = entry_idx_q;
  assign done_o         = done_q;

endmodule
`default_nettype wire
